// File: rtl/parking_lot_ctrl_pkg.sv
// Shared types and width helper for the parking lot controller slice.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY_OPEN,
    EXIT_OPEN
  } state_t;

  // Smallest r such that 2**r >= n; usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/parking_lot_ctrl_if.sv
// Request/status bundle between the gate client and the parking lot controller.
interface parking_lot_ctrl_if
  import parking_pkg::*;
#(
  parameter int NUM_SPOTS = 8
);
  localparam int SPOT_W = clog2(NUM_SPOTS);
  localparam int CNT_W  = clog2(NUM_SPOTS + 1);

  logic                 enter;
  logic                 exit;
  logic [SPOT_W-1:0]    exit_spot;
  logic [NUM_SPOTS-1:0] occupancy;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 empty;
  logic                 door_open;
  logic [SPOT_W-1:0]    assigned_spot;
  logic                 assign_valid;
  logic                 exit_err;

  modport master (
    output enter, exit, exit_spot,
    input  occupancy, count, full, empty, door_open,
    input  assigned_spot, assign_valid, exit_err
  );

  modport slave (
    input  enter, exit, exit_spot,
    output occupancy, count, full, empty, door_open,
    output assigned_spot, assign_valid, exit_err
  );

endinterface

// File: rtl/parking_lot_ctrl_lowest_free_finder.sv
// Combinational priority encoder returning the lowest-index free spot.
module lowest_free_finder
  import parking_pkg::*;
#(
  parameter int NUM_SPOTS = 8
) (
  input  logic [NUM_SPOTS-1:0]        occupancy,
  output logic [clog2(NUM_SPOTS)-1:0] index,
  output logic                        found
);
  localparam int SPOT_W = clog2(NUM_SPOTS);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        index = SPOT_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking lot controller: spot allocation, occupancy tracking and a timed gate.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_SPOTS   = 8,
  parameter int DOOR_CYCLES = 4
) (
  input logic               CLK,
  input logic               RST,
  parking_lot_ctrl_if.slave bus
);
  localparam int SPOT_W = clog2(NUM_SPOTS);
  localparam int CNT_W  = clog2(NUM_SPOTS + 1);
  localparam int TMR_W  = 8;

  state_t               state, state_nxt;
  logic [TMR_W-1:0]     timer, timer_nxt;
  logic [NUM_SPOTS-1:0] occupancy, occupancy_nxt;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [SPOT_W-1:0]    assigned_spot, assigned_spot_nxt;
  logic                 assign_valid, assign_valid_nxt;
  logic                 exit_err, exit_err_nxt;
  logic                 door_open;
  logic [SPOT_W-1:0]    free_idx;
  logic                 free_found;
  logic                 full;
  logic                 exit_in_range;
  logic                 exit_ok;

  lowest_free_finder #(.NUM_SPOTS(NUM_SPOTS)) u_finder (
    .occupancy (occupancy),
    .index     (free_idx),
    .found     (free_found)
  );

  assign full          = (count == CNT_W'(NUM_SPOTS));
  assign exit_in_range = (int'(bus.exit_spot) < NUM_SPOTS);
  assign exit_ok       = bus.exit && exit_in_range && occupancy[bus.exit_spot];

  // A valid exit wins over enter; an invalid exit only flags an error.
  always_comb begin
    state_nxt         = state;
    timer_nxt         = timer;
    occupancy_nxt     = occupancy;
    count_nxt         = count;
    assigned_spot_nxt = assigned_spot;
    assign_valid_nxt  = 1'b0;
    exit_err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (exit_ok) begin
          occupancy_nxt[bus.exit_spot] = 1'b0;
          count_nxt                    = count - CNT_W'(1);
          timer_nxt                    = TMR_W'(DOOR_CYCLES - 1);
          state_nxt                    = EXIT_OPEN;
        end else begin
          exit_err_nxt = bus.exit;
          if (bus.enter && !full && free_found) begin
            occupancy_nxt[free_idx] = 1'b1;
            count_nxt               = count + CNT_W'(1);
            assigned_spot_nxt       = free_idx;
            assign_valid_nxt        = 1'b1;
            timer_nxt               = TMR_W'(DOOR_CYCLES - 1);
            state_nxt               = ENTRY_OPEN;
          end
        end
      end
      default: begin
        if (timer == '0) begin
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      timer         <= '0;
      occupancy     <= '0;
      count         <= '0;
      assigned_spot <= '0;
      assign_valid  <= 1'b0;
      exit_err      <= 1'b0;
      door_open     <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      occupancy     <= occupancy_nxt;
      count         <= count_nxt;
      assigned_spot <= assigned_spot_nxt;
      assign_valid  <= assign_valid_nxt;
      exit_err      <= exit_err_nxt;
      door_open     <= (state_nxt != IDLE);
    end
  end

  assign bus.occupancy     = occupancy;
  assign bus.count         = count;
  assign bus.full          = full;
  assign bus.empty         = (count == '0);
  assign bus.door_open     = door_open;
  assign bus.assigned_spot = assigned_spot;
  assign bus.assign_valid  = assign_valid;
  assign bus.exit_err      = exit_err;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed and randomized checks of parking_lot_ctrl against a spot-list model.
module tb_parking_lot_ctrl;
  localparam int N = 4;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parking_lot_ctrl_if #(.NUM_SPOTS(N)) bus ();

  parking_lot_ctrl #(.NUM_SPOTS(N), .DOOR_CYCLES(D)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: list of occupied spots plus remaining open cycles of the gate.
  int m_occ[N];
  int m_door;
  int m_spot;
  int m_av;
  int m_err;

  function automatic int m_count();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) c += m_occ[i];
    return c;
  endfunction

  task automatic model_edge(input bit r, input bit en, input bit ex, input int sp);
    int lo;
    if (r) begin
      for (int i = 0; i < N; i++) m_occ[i] = 0;
      m_door = 0; m_spot = 0; m_av = 0; m_err = 0;
      return;
    end
    m_av  = 0;
    m_err = 0;
    if (m_door > 0) begin
      m_door--;
    end else if (ex && sp < N && m_occ[sp] == 1) begin
      m_occ[sp] = 0;
      m_door    = D;
    end else begin
      if (ex) m_err = 1;
      if (en && m_count() < N) begin
        lo = -1;
        for (int i = N - 1; i >= 0; i--) if (m_occ[i] == 0) lo = i;
        m_occ[lo] = 1;
        m_spot    = lo;
        m_av      = 1;
        m_door    = D;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] eo;
    int ec;
    eo = '0;
    ec = m_count();
    for (int i = 0; i < N; i++) if (m_occ[i] == 1) eo[i] = 1'b1;
    check("occupancy",     32'(bus.occupancy),     eo);
    check("count",         32'(bus.count),         32'(ec));
    check("full",          32'(bus.full),          32'(ec == N));
    check("empty",         32'(bus.empty),         32'(ec == 0));
    check("door_open",     32'(bus.door_open),     32'(m_door > 0));
    check("assigned_spot", 32'(bus.assigned_spot), 32'(m_spot));
    check("assign_valid",  32'(bus.assign_valid),  32'(m_av));
    check("exit_err",      32'(bus.exit_err),      32'(m_err));
  endtask

  task automatic step(input bit r, input bit en, input bit ex, input int sp);
    rst           = r;
    bus.enter     = en;
    bus.exit      = ex;
    bus.exit_spot = sp[1:0];
    @(posedge clk);
    model_edge(r, en, ex, sp);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int open_cycles;
    bit r, en, ex;
    int sp;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    check("reset_empty", 32'(bus.empty), 32'd1);
    check("reset_door",  32'(bus.door_open), 32'd0);

    // First admission and exact door length
    step(0, 1, 0, 0);
    check("first_spot",  32'(bus.assigned_spot), 32'd0);
    check("first_valid", 32'(bus.assign_valid), 32'd1);
    check("first_occ",   32'(bus.occupancy), 32'b0001);
    open_cycles = int'(bus.door_open);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      open_cycles += int'(bus.door_open);
    end
    check("door_len", 32'(open_cycles), 32'(D));

    // Fill the lot; a further enter is ignored
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0);
      idle(D);
    end
    check("fill_occ",  32'(bus.occupancy), 32'b1111);
    check("fill_full", 32'(bus.full), 32'd1);
    step(0, 1, 0, 0);
    check("full_no_door",  32'(bus.door_open), 32'd0);
    check("full_no_valid", 32'(bus.assign_valid), 32'd0);

    // Free spot 2, then it is the next one handed out
    step(0, 0, 1, 2);
    check("exit2_occ", 32'(bus.occupancy), 32'b1011);
    idle(D);
    step(0, 1, 0, 0);
    check("reuse_spot", 32'(bus.assigned_spot), 32'd2);
    idle(D);

    // Invalid exit, enter+valid exit, enter+invalid exit
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    idle(D);
    step(0, 0, 1, 3);
    check("bad_exit_err",  32'(bus.exit_err), 32'd1);
    check("bad_exit_door", 32'(bus.door_open), 32'd0);
    check("bad_exit_occ",  32'(bus.occupancy), 32'b0001);
    step(0, 1, 1, 0);
    check("both_exit_only", 32'(bus.occupancy), 32'b0000);
    idle(D);
    step(0, 1, 1, 3);
    check("bad_exit_enter", 32'(bus.occupancy), 32'b0001);

    // Enter during open window ignored; reset during exit door
    step(0, 1, 0, 0);
    check("open_enter_ignored", 32'(bus.count), 32'd1);
    idle(D);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    check("rst_mid_door",  32'(bus.door_open), 32'd0);
    check("rst_mid_empty", 32'(bus.empty), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 79) == 0);
      en = 1'($urandom_range(0, 1));
      ex = ($urandom_range(0, 2) == 0);
      sp = int'($urandom_range(0, N - 1));
      step(r, en, ex, sp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
